// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller: FSM state codes,
// cause-register layout and the standard exception codes.
package trap_pkg;

  typedef logic [1:0] trap_state_t;

  localparam trap_state_t ST_IDLE  = 2'd0;
  localparam trap_state_t ST_DRAIN = 2'd1;
  localparam trap_state_t ST_TRAP  = 2'd2;

  localparam int          CAUSE_INT_BIT = 63;
  localparam logic [5:0]  CAUSE_MTI     = 6'd7;

  localparam logic [5:0]  EXC_INSN_MISALIGN = 6'd0;
  localparam logic [5:0]  EXC_INSN_FAULT    = 6'd1;
  localparam logic [5:0]  EXC_ILLEGAL_INSN  = 6'd2;
  localparam logic [5:0]  EXC_BREAKPOINT    = 6'd3;
  localparam logic [5:0]  EXC_LOAD_FAULT    = 6'd5;
  localparam logic [5:0]  EXC_STORE_FAULT   = 6'd7;
  localparam logic [5:0]  EXC_ECALL         = 6'd11;

  function automatic logic [63:0] make_cause(input logic is_int, input logic [5:0] code);
    logic [63:0] c;
    c                = '0;
    c[CAUSE_INT_BIT] = is_int;
    c[5:0]           = code;
    return c;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Interrupt priority encoder: lowest request index wins; the top request bit
// is the machine timer and maps to CAUSE_MTI.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int NUM_IRQ  = 4,
  parameter int IRQ_BASE = 16
) (
  input  logic [NUM_IRQ:0] req,
  output logic             valid,
  output logic [5:0]       code
);

  // Scan from the weakest request upward so the strongest overwrites last.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int i = NUM_IRQ; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        code  = (i == NUM_IRQ) ? CAUSE_MTI : 6'(IRQ_BASE + i);
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap initiator: prioritises exceptions/interrupts, drains the pipe and issues
// the one-cycle context-switch request. Optional machine timer under TRAP_TIMER_EN.
//
// state    | meaning
// ST_IDLE  | waiting for an exception or enabled interrupt
// ST_DRAIN | FLUSH asserted, waiting for PIPE_EMPTY or drain timeout
// ST_TRAP  | CS pulse with latched CAUSE/NPC, enter handler
module trap_controller
  import trap_pkg::*;
#(
  parameter int NUM_IRQ   = 4,
  parameter int IRQ_BASE  = 16,
  parameter int DRAIN_MAX = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EXC_VALID,
  input  logic [5:0]         EXC_CODE,
  input  logic [63:0]        EXC_PC,
  input  logic [63:0]        RETIRE_PC,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [NUM_IRQ-1:0] IRQ_MASK,
  input  logic               GIE,
  input  logic               PIPE_EMPTY,
  input  logic               RET_RETIRED,
  input  logic               TIMECMP_WE,
  input  logic [63:0]        TIMECMP_DATA,
  output logic               FLUSH,
  output logic               CS,
  output logic [63:0]        CAUSE,
  output logic [63:0]        NPC,
  output logic               IN_TRAP,
  output logic [63:0]        MTIME
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  trap_state_t      state;
  logic [CNT_W-1:0] drain_cnt;
  logic             drain_last;
  logic             timer_irq;
  logic             irq_valid;
  logic [5:0]       irq_code;
  logic             int_take;

`ifdef TRAP_TIMER_EN
  logic [63:0] mtime_q;
  logic [63:0] timecmp;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mtime_q <= '0;
      timecmp <= '1;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (TIMECMP_WE) timecmp <= TIMECMP_DATA;
    end
  end

  assign timer_irq = (mtime_q >= timecmp);
  assign MTIME     = mtime_q;
`else
  logic unused_timecmp;

  assign unused_timecmp = ^{TIMECMP_WE, TIMECMP_DATA};
  assign timer_irq      = 1'b0;
  assign MTIME          = '0;
`endif

  trap_prio_enc #(
    .NUM_IRQ  (NUM_IRQ),
    .IRQ_BASE (IRQ_BASE)
  ) u_prio (
    .req   ({timer_irq, IRQ & IRQ_MASK}),
    .valid (irq_valid),
    .code  (irq_code)
  );

  assign int_take   = GIE & ~IN_TRAP & irq_valid;
  assign drain_last = (drain_cnt == CNT_W'(DRAIN_MAX - 1));
  assign CS         = (state == ST_TRAP);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      FLUSH     <= 1'b0;
      CAUSE     <= '0;
      NPC       <= '0;
      IN_TRAP   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (EXC_VALID) begin
            CAUSE <= make_cause(1'b0, EXC_CODE);
            NPC   <= EXC_PC;
            FLUSH <= 1'b1;
            state <= ST_DRAIN;
          end else if (int_take) begin
            CAUSE <= make_cause(1'b1, irq_code);
            NPC   <= RETIRE_PC;
            FLUSH <= 1'b1;
            state <= ST_DRAIN;
          end else if (RET_RETIRED) begin
            IN_TRAP <= 1'b0;
          end
        end
        // Timeout fires once DRAIN_MAX drain cycles have elapsed.
        ST_DRAIN: begin
          if (PIPE_EMPTY || drain_last) begin
            state     <= ST_TRAP;
            FLUSH     <= 1'b0;
            drain_cnt <= '0;
          end else if (drain_cnt != CNT_W'(DRAIN_MAX)) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_TRAP: begin
          IN_TRAP <= 1'b1;
          FLUSH   <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_trap_controller;

  localparam int NUM_IRQ   = 4;
  localparam int IRQ_BASE  = 16;
  localparam int DRAIN_MAX = 15;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         EXC_VALID;
  logic [5:0]   EXC_CODE;
  logic [63:0]  EXC_PC;
  logic [63:0]  RETIRE_PC;
  logic [3:0]   IRQ;
  logic [3:0]   IRQ_MASK;
  logic         GIE;
  logic         PIPE_EMPTY;
  logic         RET_RETIRED;
  logic         TIMECMP_WE;
  logic [63:0]  TIMECMP_DATA;
  logic         FLUSH;
  logic         CS;
  logic [63:0]  CAUSE;
  logic [63:0]  NPC;
  logic         IN_TRAP;
  logic [63:0]  MTIME;

  int total = 0;
  int bad   = 0;

  trap_controller #(
    .NUM_IRQ   (NUM_IRQ),
    .IRQ_BASE  (IRQ_BASE),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .EXC_VALID    (EXC_VALID),
    .EXC_CODE     (EXC_CODE),
    .EXC_PC       (EXC_PC),
    .RETIRE_PC    (RETIRE_PC),
    .IRQ          (IRQ),
    .IRQ_MASK     (IRQ_MASK),
    .GIE          (GIE),
    .PIPE_EMPTY   (PIPE_EMPTY),
    .RET_RETIRED  (RET_RETIRED),
    .TIMECMP_WE   (TIMECMP_WE),
    .TIMECMP_DATA (TIMECMP_DATA),
    .FLUSH        (FLUSH),
    .CS           (CS),
    .CAUSE        (CAUSE),
    .NPC          (NPC),
    .IN_TRAP      (IN_TRAP),
    .MTIME        (MTIME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        exc;
    logic [5:0]  code;
    logic [63:0] epc;
    logic [63:0] rpc;
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic        gie;
    logic        ev;
    logic [63:0] cause;
    logic [63:0] npc;
  } vec_t;

  vec_t vecs[8];

  // behavioural model state
  logic        m_flush, m_cs, m_in_trap, m_busy;
  logic [63:0] m_cause, m_npc, m_mtime, m_timecmp;
  int          m_drained;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EXC_VALID = 0; EXC_CODE = 0; EXC_PC = 0; RETIRE_PC = 0;
    IRQ = 0; IRQ_MASK = 0; GIE = 0; PIPE_EMPTY = 1; RET_RETIRED = 0;
    TIMECMP_WE = 0; TIMECMP_DATA = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1;
    tick();
    tick();
    RESET = 0;
  endtask

  // One model cycle: consumes the inputs of the current cycle, yields outputs after the edge.
  task automatic model_step();
    int  win;
    logic [3:0] act;
    logic tmr;
    act = IRQ & IRQ_MASK;
    win = -1;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (act[i]) win = i;
    tmr = 1'b0;
`ifdef TRAP_TIMER_EN
    tmr = (m_mtime >= m_timecmp);
    if (TIMECMP_WE) m_timecmp = TIMECMP_DATA;
    m_mtime = m_mtime + 1;
`endif
    if (m_cs) begin
      m_cs = 0;
      m_in_trap = 1;
    end else if (m_busy) begin
      m_drained++;
      if (PIPE_EMPTY || m_drained == DRAIN_MAX) begin
        m_busy = 0; m_flush = 0; m_cs = 1;
      end
    end else if (EXC_VALID) begin
      m_cause = {58'd0, EXC_CODE}; m_npc = EXC_PC;
      m_busy = 1; m_flush = 1; m_drained = 0;
    end else if (GIE && !m_in_trap && (win >= 0 || tmr)) begin
      m_cause = {1'b1, 57'd0, (win >= 0) ? 6'(IRQ_BASE + win) : 6'd7};
      m_npc = RETIRE_PC;
      m_busy = 1; m_flush = 1; m_drained = 0;
    end else if (RET_RETIRED) begin
      m_in_trap = 0;
    end
  endtask

  initial begin
    int flush_cycles;
    int cs_seen;

    vecs[0] = '{1'b1, 6'd2,  64'h1000, 64'h0,    4'b0000, 4'b0000, 1'b0, 1'b1, 64'h2,                   64'h1000};
    vecs[1] = '{1'b0, 6'd0,  64'h0,    64'h2004, 4'b0110, 4'b1111, 1'b1, 1'b1, 64'h8000_0000_0000_0011, 64'h2004};
    vecs[2] = '{1'b1, 6'd5,  64'h1abc, 64'h2222, 4'b0001, 4'b1111, 1'b1, 1'b1, 64'h5,                   64'h1abc};
    vecs[3] = '{1'b0, 6'd0,  64'h0,    64'h3300, 4'b1000, 4'b1000, 1'b1, 1'b1, 64'h8000_0000_0000_0013, 64'h3300};
    vecs[4] = '{1'b0, 6'd0,  64'h0,    64'h4400, 4'b1111, 4'b1100, 1'b1, 1'b1, 64'h8000_0000_0000_0012, 64'h4400};
    vecs[5] = '{1'b0, 6'd0,  64'h0,    64'h5500, 4'b1111, 4'b1111, 1'b0, 1'b0, 64'h0,                   64'h0};
    vecs[6] = '{1'b0, 6'd0,  64'h0,    64'h6600, 4'b0101, 4'b1010, 1'b1, 1'b0, 64'h0,                   64'h0};
    vecs[7] = '{1'b1, 6'd15, 64'hdead, 64'h0,    4'b0000, 4'b0000, 1'b0, 1'b1, 64'hf,                   64'hdead};

    do_reset();
    chk("rst_flush", 64'(FLUSH), 64'h0);
    chk("rst_cs", 64'(CS), 64'h0);
    chk("rst_cause", CAUSE, 64'h0);
    chk("rst_npc", NPC, 64'h0);
    chk("rst_in_trap", 64'(IN_TRAP), 64'h0);
    chk("rst_mtime", MTIME, 64'h0);

    // vector table
    for (int k = 0; k < 8; k++) begin
      do_reset();
      EXC_VALID = vecs[k].exc; EXC_CODE = vecs[k].code; EXC_PC = vecs[k].epc;
      RETIRE_PC = vecs[k].rpc; IRQ = vecs[k].irq; IRQ_MASK = vecs[k].mask; GIE = vecs[k].gie;
      tick();
      EXC_VALID = 0; IRQ = 0;
      chk($sformatf("v%0d_flush", k), 64'(FLUSH), 64'(vecs[k].ev));
      chk($sformatf("v%0d_cs_early", k), 64'(CS), 64'h0);
      tick();
      chk($sformatf("v%0d_cs", k), 64'(CS), 64'(vecs[k].ev));
      chk($sformatf("v%0d_cause", k), CAUSE, vecs[k].cause);
      chk($sformatf("v%0d_npc", k), NPC, vecs[k].npc);
      tick();
      chk($sformatf("v%0d_cs_end", k), 64'(CS), 64'h0);
      chk($sformatf("v%0d_in_trap", k), 64'(IN_TRAP), 64'(vecs[k].ev));
    end

    // exception beats IRQ; IRQ blocked in trap; retaken after return
    do_reset();
    EXC_VALID = 1; EXC_CODE = 6'd3; EXC_PC = 64'h3000; RETIRE_PC = 64'h4000;
    IRQ = 4'b0001; IRQ_MASK = 4'b1111; GIE = 1;
    tick();
    EXC_VALID = 0;
    tick();
    chk("nest_cs1", 64'(CS), 64'h1);
    chk("nest_cause1", CAUSE, 64'h3);
    tick();
    chk("nest_in_trap", 64'(IN_TRAP), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nest_irq_blocked", 64'(FLUSH), 64'h0);
    end
    RET_RETIRED = 1;
    tick();
    RET_RETIRED = 0;
    chk("nest_ret_clear", 64'(IN_TRAP), 64'h0);
    tick();
    IRQ = 0;
    chk("nest_flush2", 64'(FLUSH), 64'h1);
    tick();
    chk("nest_cs2", 64'(CS), 64'h1);
    chk("nest_cause2", CAUSE, 64'h8000_0000_0000_0010);
    chk("nest_npc2", NPC, 64'h4000);
    tick();
    // return and nested exception in the same cycle: trap wins
    EXC_VALID = 1; EXC_CODE = 6'd4; EXC_PC = 64'h7000; RET_RETIRED = 1;
    tick();
    EXC_VALID = 0; RET_RETIRED = 0;
    chk("ret_ev_flush", 64'(FLUSH), 64'h1);
    chk("ret_ev_in_trap", 64'(IN_TRAP), 64'h1);
    tick();
    chk("ret_ev_cause", CAUSE, 64'h4);
    tick();
    chk("ret_ev_in_trap2", 64'(IN_TRAP), 64'h1);

    // drain timeout with the request dropped mid-drain
    do_reset();
    PIPE_EMPTY = 0; IRQ = 4'b0100; IRQ_MASK = 4'b1111; GIE = 1; RETIRE_PC = 64'h5000;
    tick();
    IRQ = 0;
    flush_cycles = 0;
    for (int i = 0; i < 100 && !CS; i++) begin
      if (FLUSH) flush_cycles++;
      tick();
    end
    chk("drain_cs", 64'(CS), 64'h1);
    chk("drain_flush_cycles", 64'(flush_cycles), 64'(DRAIN_MAX));
    chk("drain_cause", CAUSE, 64'h8000_0000_0000_0012);
    chk("drain_npc", NPC, 64'h5000);

`ifdef TRAP_TIMER_EN
    do_reset();
    GIE = 1; TIMECMP_WE = 1; TIMECMP_DATA = 64'd20; RETIRE_PC = 64'h6000;
    tick();
    TIMECMP_WE = 0;
    for (int i = 0; i < 60 && !CS; i++) tick();
    chk("tmr_cs", 64'(CS), 64'h1);
    chk("tmr_cause", CAUSE, 64'h8000_0000_0000_0007);
    tick();
    IRQ = 4'b0010; IRQ_MASK = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmr_blocked", 64'(FLUSH), 64'h0);
    end
    RET_RETIRED = 1;
    tick();
    RET_RETIRED = 0;
    tick();
    tick();
    chk("tmr_irq_over_timer", CAUSE, 64'h8000_0000_0000_0011);
    IRQ = 0;
`else
    for (int i = 0; i < 5; i++) tick();
    chk("mtime_tied_zero", MTIME, 64'h0);
`endif

    // reset while draining
    do_reset();
    EXC_VALID = 1; EXC_CODE = 6'd6; EXC_PC = 64'h8800; PIPE_EMPTY = 0;
    tick();
    EXC_VALID = 0;
    tick();
    #2 RESET = 1;
    #1;
    chk("rst_drain_flush", 64'(FLUSH), 64'h0);
    chk("rst_drain_cause", CAUSE, 64'h0);
    chk("rst_drain_npc", NPC, 64'h0);
    chk("rst_drain_cs", 64'(CS), 64'h0);
    RESET = 0;
    GIE = 1; IRQ_MASK = 4'b1111; PIPE_EMPTY = 1;
    cs_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (CS || FLUSH) cs_seen++;
    end
    chk("rst_no_trap", 64'(cs_seen), 64'h0);

    // randomized run against the model
    do_reset();
    m_flush = 0; m_cs = 0; m_in_trap = 0; m_busy = 0; m_drained = 0;
    m_cause = 0; m_npc = 0; m_mtime = 0; m_timecmp = '1;
    for (int c = 0; c < 500; c++) begin
      EXC_VALID   = ($urandom_range(9) == 0);
      EXC_CODE    = 6'($urandom_range(15));
      EXC_PC      = {$urandom, $urandom};
      RETIRE_PC   = {$urandom, $urandom};
      IRQ         = 4'($urandom);
      IRQ_MASK    = 4'($urandom);
      GIE         = ($urandom_range(3) == 0);
      PIPE_EMPTY  = ($urandom_range(3) == 0);
      RET_RETIRED = ($urandom_range(4) == 0);
      model_step();
      tick();
      chk("rnd_flush", 64'(FLUSH), 64'(m_flush));
      chk("rnd_cs", 64'(CS), 64'(m_cs));
      chk("rnd_cause", CAUSE, m_cause);
      chk("rnd_npc", NPC, m_npc);
      chk("rnd_in_trap", 64'(IN_TRAP), 64'(m_in_trap));
      chk("rnd_mtime", MTIME, m_mtime);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
